// File: rtl/reorder_buffer_mc_pkg.sv
// Shared constants for the reorder buffer: boolean aliases, op-class encodings and the
// commit-FSM state type.
package reorder_buffer_mc_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [2:0] OP_ALU    = 3'd0;
    localparam logic [2:0] OP_LOAD   = 3'd1;
    localparam logic [2:0] OP_STORE  = 3'd2;
    localparam logic [2:0] OP_BRANCH = 3'd3;
    localparam logic [2:0] OP_JUMP   = 3'd4;

    typedef enum logic {
        ROB_IDLE       = 1'b0,
        ROB_WAIT_STORE = 1'b1
    } rob_state_e;

endpackage

// File: rtl/reorder_buffer_mc_wb_match.sv
// Combinational writeback match for one ROB entry: reports whether any enabled port targets
// this entry and which port wins (lowest index has priority).
module rob_wb_match #(
    parameter int unsigned DEPTH_LOG = 4,
    parameter int unsigned WB_PORTS  = 2,
    parameter int unsigned PORT_W    = 1
) (
    input  logic [DEPTH_LOG-1:0]          entry_tag,
    input  logic [WB_PORTS-1:0]           wb_valid,
    input  logic [WB_PORTS*DEPTH_LOG-1:0] wb_tag,
    output logic                          hit,
    output logic [PORT_W-1:0]             port_sel
);

    // Scanning from the top down leaves the lowest matching port in port_sel.
    always_comb begin
        hit      = 1'b0;
        port_sel = '0;
        for (int p = WB_PORTS - 1; p >= 0; p--) begin
            if (wb_valid[p] && (wb_tag[p*DEPTH_LOG +: DEPTH_LOG] == entry_tag)) begin
                hit      = 1'b1;
                port_sel = PORT_W'(p);
            end
        end
    end

endmodule

// File: rtl/reorder_buffer_mc.sv
// Parametrised reorder buffer with store-commit handshake and internal mispredict flush.
// Define ROB_CDB_BYPASS_EN to let the head commit on the edge that captures its writeback.
module reorder_buffer_mc
    import reorder_buffer_mc_pkg::*;
#(
    parameter int unsigned DEPTH_LOG = 4,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned WB_PORTS  = 2
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          rdy_in,
    input  logic                          issue_valid,
    output logic                          issue_ready,
    output logic [DEPTH_LOG-1:0]          issue_tag,
    input  logic [4:0]                    issue_rd,
    input  logic [2:0]                    issue_op_type,
    input  logic                          issue_is_store,
    input  logic                          issue_is_branch,
    input  logic [31:0]                   issue_pc,
    input  logic [31:0]                   issue_pred_pc,
    input  logic [WB_PORTS-1:0]           wb_valid,
    input  logic [WB_PORTS*DEPTH_LOG-1:0] wb_tag,
    input  logic [WB_PORTS*DATA_W-1:0]    wb_data,
    input  logic [WB_PORTS*32-1:0]        wb_next_pc,
    output logic                          store_go,
    output logic [DEPTH_LOG-1:0]          store_go_tag,
    input  logic                          store_done,
    output logic                          commit_valid,
    output logic [DEPTH_LOG-1:0]          commit_tag,
    output logic [4:0]                    commit_rd,
    output logic [DATA_W-1:0]             commit_data,
    output logic [31:0]                   commit_pc,
    output logic                          commit_is_store,
    output logic                          flush_out,
    output logic [31:0]                   flush_pc,
    output logic [DEPTH_LOG:0]            count
);

    localparam int unsigned DEPTH  = 2 ** DEPTH_LOG;
    localparam int unsigned PORT_W = (WB_PORTS > 1) ? $clog2(WB_PORTS) : 1;
    localparam logic [DEPTH_LOG:0] CNT_FULL = (DEPTH_LOG + 1)'(DEPTH);

    logic [DEPTH_LOG-1:0] head_q, tail_q;
    logic [DEPTH_LOG:0]   count_q, count_d;
    rob_state_e           state_q;

    logic [DEPTH-1:0]  valid_q, ready_q, mispred_q, store_q, branch_q;
    logic [4:0]        rd_q   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [31:0]       pc_q   [DEPTH];
    logic [31:0]       pred_q [DEPTH];
    logic [31:0]       npc_q  [DEPTH];

    logic                 commit_valid_q, flush_q, store_go_q, commit_is_store_q;
    logic [DEPTH_LOG-1:0] commit_tag_q, store_go_tag_q;
    logic [4:0]           commit_rd_q;
    logic [DATA_W-1:0]    commit_data_q;
    logic [31:0]          commit_pc_q, flush_pc_q;

    logic [DEPTH-1:0]  wb_hit;
    logic [PORT_W-1:0] wb_sel [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_match
        rob_wb_match #(
            .DEPTH_LOG(DEPTH_LOG),
            .WB_PORTS (WB_PORTS),
            .PORT_W   (PORT_W)
        ) u_match (
            .entry_tag(DEPTH_LOG'(i)),
            .wb_valid (wb_valid),
            .wb_tag   (wb_tag),
            .hit      (wb_hit[i]),
            .port_sel (wb_sel[i])
        );
    end

    logic              head_byp, head_ok, head_mispred, issue_fire, commit_fire;
    logic [PORT_W-1:0] head_sel;
    logic [DATA_W-1:0] head_wb_data, head_data;
    logic [31:0]       head_wb_npc, head_npc;

    assign head_sel     = wb_sel[head_q];
    assign head_wb_data = wb_data[32'(head_sel) * DATA_W +: DATA_W];
    assign head_wb_npc  = wb_next_pc[32'(head_sel) * 32 +: 32];

`ifdef ROB_CDB_BYPASS_EN
    assign head_byp = wb_hit[head_q] && !ready_q[head_q];
`else
    assign head_byp = FALSE;
`endif

    assign head_ok      = valid_q[head_q] && (ready_q[head_q] || head_byp);
    assign head_data    = ready_q[head_q] ? data_q[head_q] : head_wb_data;
    assign head_npc     = ready_q[head_q] ? npc_q[head_q] : head_wb_npc;
    assign head_mispred = branch_q[head_q] &&
                          (ready_q[head_q] ? mispred_q[head_q] : (head_wb_npc != pred_q[head_q]));

    assign issue_ready = (count_q != CNT_FULL);
    assign issue_tag   = tail_q;
    assign issue_fire  = issue_valid && issue_ready;
    assign commit_fire = ((state_q == ROB_IDLE) && head_ok && !store_q[head_q]) ||
                         ((state_q == ROB_WAIT_STORE) && store_done);

    always_comb begin
        count_d = count_q;
        unique case ({issue_fire, commit_fire})
            2'b10:   count_d = count_q + (DEPTH_LOG + 1)'(1);
            2'b01:   count_d = count_q - (DEPTH_LOG + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q            <= '0;
            tail_q            <= '0;
            count_q           <= '0;
            state_q           <= ROB_IDLE;
            valid_q           <= '0;
            ready_q           <= '0;
            mispred_q         <= '0;
            store_q           <= '0;
            branch_q          <= '0;
            commit_valid_q    <= FALSE;
            flush_q           <= FALSE;
            store_go_q        <= FALSE;
            commit_is_store_q <= FALSE;
            commit_tag_q      <= '0;
            store_go_tag_q    <= '0;
            commit_rd_q       <= '0;
            commit_data_q     <= '0;
            commit_pc_q       <= '0;
            flush_pc_q        <= '0;
        end else if (rdy_in) begin
            commit_valid_q <= FALSE;
            flush_q        <= FALSE;
            store_go_q     <= FALSE;
            if (flush_q) begin
                // Mispredicted branch committed last cycle: drop everything younger.
                valid_q   <= '0;
                ready_q   <= '0;
                mispred_q <= '0;
                head_q    <= '0;
                tail_q    <= '0;
                count_q   <= '0;
                state_q   <= ROB_IDLE;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (wb_hit[i] && valid_q[i] && !ready_q[i]) begin
                        ready_q[i] <= TRUE;
                        data_q[i]  <= wb_data[32'(wb_sel[i]) * DATA_W +: DATA_W];
                        if (branch_q[i]) begin
                            npc_q[i]     <= wb_next_pc[32'(wb_sel[i]) * 32 +: 32];
                            mispred_q[i] <= wb_next_pc[32'(wb_sel[i]) * 32 +: 32] != pred_q[i];
                        end
                    end
                end
                if (issue_fire) begin
                    valid_q[tail_q]   <= TRUE;
                    ready_q[tail_q]   <= FALSE;
                    mispred_q[tail_q] <= FALSE;
                    store_q[tail_q]   <= issue_is_store;
                    branch_q[tail_q]  <= issue_is_branch;
                    rd_q[tail_q]      <= issue_rd;
                    pc_q[tail_q]      <= issue_pc;
                    pred_q[tail_q]    <= issue_pred_pc;
                    tail_q            <= tail_q + DEPTH_LOG'(1);
                end
                if (state_q == ROB_IDLE && head_ok && store_q[head_q]) begin
                    store_go_q     <= TRUE;
                    store_go_tag_q <= head_q;
                    state_q        <= ROB_WAIT_STORE;
                end
                if (commit_fire) begin
                    commit_valid_q    <= TRUE;
                    commit_tag_q      <= head_q;
                    commit_rd_q       <= rd_q[head_q];
                    commit_data_q     <= head_data;
                    commit_pc_q       <= pc_q[head_q];
                    commit_is_store_q <= (state_q == ROB_WAIT_STORE);
                    flush_q           <= (state_q == ROB_IDLE) && head_mispred;
                    flush_pc_q        <= head_npc;
                    valid_q[head_q]   <= FALSE;
                    head_q            <= head_q + DEPTH_LOG'(1);
                    state_q           <= ROB_IDLE;
                end
                count_q <= count_d;
            end
        end
    end

    // Pulses are held while stalled and only presented once rdy_in is back.
    assign commit_valid    = commit_valid_q & rdy_in;
    assign flush_out       = flush_q & rdy_in;
    assign store_go        = store_go_q & rdy_in;
    assign store_go_tag    = store_go_tag_q;
    assign commit_tag      = commit_tag_q;
    assign commit_rd       = commit_rd_q;
    assign commit_data     = commit_data_q;
    assign commit_pc       = commit_pc_q;
    assign commit_is_store = commit_is_store_q;
    assign flush_pc        = flush_pc_q;
    assign count           = count_q;

    logic unused_op_type;
    assign unused_op_type = ^issue_op_type;

endmodule
